// File: rtl/fmac_issue_ctrl.sv
// Round-robin issue control for a shared pipelined FMAC: operand muxing, valid/ID tracking, stage enables.
// Optional build macro FMAC_BUBBLE_COLLAPSE_EN: per-stage stall that squeezes bubbles out of the pipe.
module fmac_issue_ctrl #(
   parameter int NUM_REQ  = 2,
   parameter int LATENCY  = 3,
   parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    Clk_CI,
   input  logic                    Rst_RBI,
   input  logic [NUM_REQ-1:0]      Req_SI,
   output logic [NUM_REQ-1:0]      Gnt_SO,
   input  logic [NUM_REQ*32-1:0]   Operand_a_DI,
   input  logic [NUM_REQ*32-1:0]   Operand_b_DI,
   input  logic [NUM_REQ*32-1:0]   Operand_c_DI,
   input  logic [NUM_REQ*3-1:0]    RM_DI,
   output logic [31:0]             Operand_a_DO,
   output logic [31:0]             Operand_b_DO,
   output logic [31:0]             Operand_c_DO,
   output logic [2:0]              RM_DO,
   output logic [LATENCY-1:0]      Stage_en_SO,
   output logic                    Res_valid_SO,
   output logic [ID_WIDTH-1:0]     Res_id_DO,
   input  logic                    Res_ready_SI,
   input  logic                    Flush_SI,
   output logic                    Busy_SO
);

   localparam logic [ID_WIDTH:0]   NUM_REQ_EXT = (ID_WIDTH+1)'(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] LAST_ID     = ID_WIDTH'(NUM_REQ - 1);

   logic [LATENCY-1:0]  Valid_q, Valid_d;
   logic [ID_WIDTH-1:0] Id_q [LATENCY];
   logic [ID_WIDTH-1:0] Id_d [LATENCY];
   logic [ID_WIDTH-1:0] Prio_q, Prio_d;

   logic                stall;
   logic                issue;
   logic                found;
   logic [ID_WIDTH:0]   cand;
   logic [ID_WIDTH-1:0] gnt_idx;
   logic [ID_WIDTH-1:0] op_sel;
   logic [LATENCY-1:0]  hold;
   logic [LATENCY-1:0]  in_valid;
   logic [ID_WIDTH-1:0] in_id [LATENCY];

   logic [31:0] a_arr  [NUM_REQ];
   logic [31:0] b_arr  [NUM_REQ];
   logic [31:0] c_arr  [NUM_REQ];
   logic [2:0]  rm_arr [NUM_REQ];

   genvar gi;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign a_arr[gi]  = Operand_a_DI[gi*32 +: 32];
         assign b_arr[gi]  = Operand_b_DI[gi*32 +: 32];
         assign c_arr[gi]  = Operand_c_DI[gi*32 +: 32];
         assign rm_arr[gi] = RM_DI[gi*3 +: 3];
      end
   endgenerate

   assign stall = Valid_q[LATENCY-1] & ~Res_ready_SI;

   // A stage holds when it is part of the valid run ending at a blocked output.
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_hold
`ifdef FMAC_BUBBLE_COLLAPSE_EN
         assign hold[gi] = stall & (&Valid_q[LATENCY-1:gi]);
`else
         assign hold[gi] = stall;
`endif
      end
   endgenerate

   always_comb begin
      found   = 1'b0;
      gnt_idx = Prio_q;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, Prio_q} + (ID_WIDTH+1)'(i);
         if (cand >= NUM_REQ_EXT) begin
            cand = cand - NUM_REQ_EXT;
         end
         if (!found && Req_SI[cand[ID_WIDTH-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[ID_WIDTH-1:0];
         end
      end
   end

   // Reset gates issue so no grant leaks out while the state is being cleared.
   assign issue = found & ~hold[0] & ~Flush_SI & Rst_RBI;

   always_comb begin
      Gnt_SO = '0;
      if (issue) begin
         Gnt_SO[gnt_idx] = 1'b1;
      end
   end

   assign op_sel       = issue ? gnt_idx : Prio_q;
   assign Operand_a_DO = a_arr[op_sel];
   assign Operand_b_DO = b_arr[op_sel];
   assign Operand_c_DO = c_arr[op_sel];
   assign RM_DO        = rm_arr[op_sel];

   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign in_valid[gi] = issue;
            assign in_id[gi]    = gnt_idx;
         end else begin : g_body
            assign in_valid[gi] = Valid_q[gi-1];
            assign in_id[gi]    = Id_q[gi-1];
         end
         assign Stage_en_SO[gi] = ~hold[gi] & in_valid[gi];
         assign Id_d[gi]        = hold[gi] ? Id_q[gi] : in_id[gi];
      end
   endgenerate

   always_comb begin
      if (Flush_SI) begin
         Valid_d = '0;
      end else begin
         Valid_d = (hold & Valid_q) | (~hold & in_valid);
      end
   end

   assign Prio_d = issue ? ((gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_WIDTH'(1)) : Prio_q;

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         Valid_q <= '0;
         Prio_q  <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            Id_q[k] <= '0;
         end
      end else begin
         Valid_q <= Valid_d;
         Prio_q  <= Prio_d;
         Id_q    <= Id_d;
      end
   end

   assign Res_valid_SO = Valid_q[LATENCY-1];
   assign Res_id_DO    = Id_q[LATENCY-1];
   assign Busy_SO      = |Valid_q;

endmodule

// File: tb/tb_fmac_issue_ctrl.sv
// Scoreboard bench for fmac_issue_ctrl: slot-level pipeline model plus an ID queue checked by a monitor.
module tb_fmac_issue_ctrl;

   localparam int NUM_REQ  = 2;
   localparam int LATENCY  = 3;
   localparam int ID_WIDTH = 1;

   logic                  clk = 1'b0;
   logic                  Rst_RBI;
   logic [NUM_REQ-1:0]    Req_SI;
   logic [NUM_REQ-1:0]    Gnt_SO;
   logic [NUM_REQ*32-1:0] Operand_a_DI, Operand_b_DI, Operand_c_DI;
   logic [NUM_REQ*3-1:0]  RM_DI;
   logic [31:0]           Operand_a_DO, Operand_b_DO, Operand_c_DO;
   logic [2:0]            RM_DO;
   logic [LATENCY-1:0]    Stage_en_SO;
   logic                  Res_valid_SO;
   logic [ID_WIDTH-1:0]   Res_id_DO;
   logic                  Res_ready_SI;
   logic                  Flush_SI;
   logic                  Busy_SO;

   always #5 clk = ~clk;

   fmac_issue_ctrl #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .ID_WIDTH(ID_WIDTH)) dut (
      .Clk_CI       (clk),
      .Rst_RBI      (Rst_RBI),
      .Req_SI       (Req_SI),
      .Gnt_SO       (Gnt_SO),
      .Operand_a_DI (Operand_a_DI),
      .Operand_b_DI (Operand_b_DI),
      .Operand_c_DI (Operand_c_DI),
      .RM_DI        (RM_DI),
      .Operand_a_DO (Operand_a_DO),
      .Operand_b_DO (Operand_b_DO),
      .Operand_c_DO (Operand_c_DO),
      .RM_DO        (RM_DO),
      .Stage_en_SO  (Stage_en_SO),
      .Res_valid_SO (Res_valid_SO),
      .Res_id_DO    (Res_id_DO),
      .Res_ready_SI (Res_ready_SI),
      .Flush_SI     (Flush_SI),
      .Busy_SO      (Busy_SO)
   );

   int errors = 0;
   int checks = 0;
   int exp_q [$];

   // Model: each pipe slot holds the requester index of its operation, or -1 when empty.
   int mdl_pipe [LATENCY];
   int mdl_ptr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic mdl_reset();
      for (int k = 0; k < LATENCY; k++) mdl_pipe[k] = -1;
      mdl_ptr = 0;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NUM_REQ; i++) begin
         Operand_a_DI[i*32 +: 32] = $urandom();
         Operand_b_DI[i*32 +: 32] = $urandom();
         Operand_c_DI[i*32 +: 32] = $urandom();
         RM_DI[i*3 +: 3]          = 3'($urandom_range(0, 7));
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input logic [NUM_REQ-1:0] req, input logic rdy, input logic fl);
      logic               out_stall, frozen;
      logic               hold [LATENCY];
      int                 nxt [LATENCY];
      int                 g, sel, idx;
      logic [NUM_REQ-1:0] exp_gnt;
      logic [LATENCY-1:0] exp_en, exp_vld;

      Req_SI       = req;
      Res_ready_SI = rdy;
      Flush_SI     = fl;
      #1;
      out_stall = (mdl_pipe[LATENCY-1] >= 0) && !rdy;
      frozen    = out_stall;
      for (int k = LATENCY-1; k >= 0; k--) begin
`ifdef FMAC_BUBBLE_COLLAPSE_EN
         hold[k] = frozen && (mdl_pipe[k] >= 0);
         frozen  = hold[k];
`else
         hold[k] = out_stall;
`endif
      end
      g = -1;
      if (!fl && !hold[0]) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = (mdl_ptr + i) % NUM_REQ;
            if (g < 0 && req[idx]) g = idx;
         end
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      sel = (g >= 0) ? g : mdl_ptr;
      for (int k = 0; k < LATENCY; k++) begin
         exp_vld[k] = (mdl_pipe[k] >= 0);
         if (k == 0) exp_en[k] = !hold[k] && (g >= 0);
         else        exp_en[k] = !hold[k] && (mdl_pipe[k-1] >= 0);
      end

      check("gnt",       64'(Gnt_SO),       64'(exp_gnt));
      check("stage_en",  64'(Stage_en_SO),  64'(exp_en));
      check("valid_vec", 64'(dut.Valid_q),  64'(exp_vld));
      check("res_valid", 64'(Res_valid_SO), 64'(exp_vld[LATENCY-1]));
      check("busy",      64'(Busy_SO),      64'(|exp_vld));
      if (exp_vld[LATENCY-1]) check("res_id", 64'(Res_id_DO), 64'(mdl_pipe[LATENCY-1]));
      check("op_a", 64'(Operand_a_DO), 64'(Operand_a_DI[sel*32 +: 32]));
      check("op_b", 64'(Operand_b_DO), 64'(Operand_b_DI[sel*32 +: 32]));
      check("op_c", 64'(Operand_c_DO), 64'(Operand_c_DI[sel*32 +: 32]));
      check("rm",   64'(RM_DO),        64'(RM_DI[sel*3 +: 3]));
      if (g >= 0) exp_q.push_back(g);

      @(posedge clk);
      for (int k = 0; k < LATENCY; k++) begin
         if (fl)           nxt[k] = -1;
         else if (hold[k]) nxt[k] = mdl_pipe[k];
         else if (k == 0)  nxt[k] = g;
         else              nxt[k] = mdl_pipe[k-1];
      end
      for (int k = 0; k < LATENCY; k++) mdl_pipe[k] = nxt[k];
      if (g >= 0) mdl_ptr = (g + 1) % NUM_REQ;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      Rst_RBI = 1'b0;
      Req_SI  = '1;
      #1;
      check("rst_gnt",       64'(Gnt_SO),       64'(0));
      check("rst_res_valid", 64'(Res_valid_SO), 64'(0));
      check("rst_busy",      64'(Busy_SO),      64'(0));
      check("rst_stage_en",  64'(Stage_en_SO),  64'(0));
      check("rst_res_id",    64'(Res_id_DO),    64'(0));
      mdl_reset();
      @(negedge clk);
      Rst_RBI = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every accepted result.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         #2;
         if (!Rst_RBI) begin
            exp_q.delete();
         end else begin
            if (Res_valid_SO && Res_ready_SI) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result actual=%0d required=none t=%0t", Res_id_DO, $time);
               end else begin
                  e = exp_q.pop_front();
                  $display("result id=%0d expected=%0d t=%0t", Res_id_DO, e, $time);
                  check("sb_id", 64'(Res_id_DO), 64'(e));
               end
            end
            if (Flush_SI) exp_q.delete();
         end
      end
   end

   initial begin
      logic [LATENCY-1:0] bubble_exp;
      Rst_RBI      = 1'b0;
      Req_SI       = '0;
      Res_ready_SI = 1'b1;
      Flush_SI     = 1'b0;
      rand_ops();
      mdl_reset();
      @(negedge clk);
      apply_reset();

      // Round-robin with both requesting
      repeat (4) cycle(2'b11, 1'b1, 1'b0);
      repeat (LATENCY) cycle(2'b00, 1'b1, 1'b0);

      // Operand routing from requester 1
      Operand_a_DI[63:32] = 32'h3F80_0000;
      Operand_b_DI[63:32] = 32'h4000_0000;
      Operand_c_DI[63:32] = 32'h4040_0000;
      RM_DI[5:3]          = 3'b001;
      cycle(2'b10, 1'b1, 1'b0);
      repeat (LATENCY) cycle(2'b00, 1'b1, 1'b0);

      // Back-pressure on a full pipe
      rand_ops();
      repeat (3) cycle(2'b11, 1'b1, 1'b0);
      repeat (5) cycle(2'b11, 1'b0, 1'b0);
      repeat (4) cycle(2'b11, 1'b1, 1'b0);
      repeat (LATENCY) cycle(2'b00, 1'b1, 1'b0);

      // Flush with three in flight
      repeat (3) cycle(2'b11, 1'b1, 1'b0);
      cycle(2'b11, 1'b1, 1'b1);
      cycle(2'b00, 1'b1, 1'b0);
      cycle(2'b11, 1'b1, 1'b0);
      repeat (LATENCY) cycle(2'b00, 1'b1, 1'b0);

      // Bubble then output stall
      cycle(2'b01, 1'b1, 1'b0);
      cycle(2'b00, 1'b1, 1'b0);
      cycle(2'b10, 1'b1, 1'b0);
      repeat (3) cycle(2'b11, 1'b0, 1'b0);
`ifdef FMAC_BUBBLE_COLLAPSE_EN
      bubble_exp = 3'b111;
`else
      bubble_exp = 3'b101;
`endif
      check("bubble_valid", 64'(dut.Valid_q), 64'(bubble_exp));
      repeat (LATENCY + 2) cycle(2'b00, 1'b1, 1'b0);

      // Reset in the middle of operations
      repeat (2) cycle(2'b11, 1'b1, 1'b0);
      apply_reset();
      cycle(2'b11, 1'b1, 1'b0);

      // Random traffic
      repeat (400) begin
         rand_ops();
         cycle(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
      end
      repeat (LATENCY + 2) cycle(2'b00, 1'b1, 1'b0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fmac_issue_ctrl.md
Name: fmac_issue_ctrl

Overview:
- Shares one pipelined FMAC datapath (multiplier, aligner, adders/LZA, normalise/round) between NUM_REQ requesters.
- Round-robin arbitration picks one requester per cycle and muxes its operands into the datapath input registers.
- A valid/ID shift chain tracks each operation through the pipe and drives per-stage register enables.
- Back-pressure from the result consumer stalls the pipe; a flush discards all in-flight operations.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LATENCY, 3, FMAC register stages from operand capture to result (1..6).
- ID_WIDTH, 1, width of requester index = max(1, clog2(NUM_REQ)).

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  asynchronous active-low reset
- Req_SI  in  NUM_REQ  per-requester operation request
- Gnt_SO  out  NUM_REQ  one-hot grant; operation accepted when Req_SI[i]&Gnt_SO[i]
- Operand_a_DI  in  NUM_REQ*32  per-requester operand a (requester i at bits [32i+31:32i])
- Operand_b_DI  in  NUM_REQ*32  per-requester operand b
- Operand_c_DI  in  NUM_REQ*32  per-requester operand c
- RM_DI  in  NUM_REQ*3  per-requester rounding mode
- Operand_a_DO  out  32  muxed operand a to FMAC stage-0 register
- Operand_b_DO  out  32  muxed operand b
- Operand_c_DO  out  32  muxed operand c
- RM_DO  out  3  muxed rounding mode
- Stage_en_SO  out  LATENCY  register enable per FMAC stage (bit 0 = operand capture)
- Res_valid_SO  out  1  result valid at FMAC output
- Res_id_DO  out  ID_WIDTH  requester index of current result
- Res_ready_SI  in  1  consumer accepts result
- Flush_SI  in  1  synchronous kill of all in-flight operations
- Busy_SO  out  1  any stage holds a valid operation

Behaviour:
- Internal state: Valid_q[LATENCY], Id_q[LATENCY], round-robin pointer Prio_q (ID_WIDTH). Reset: all zero, so Gnt_SO=0, Res_valid_SO=0, Busy_SO=0, Stage_en_SO=0, Res_id_DO=0.
- Stall = Valid_q[LATENCY-1] & ~Res_ready_SI.
- Arbitration (combinational): if ~Stall & ~Flush_SI, grant the first asserted Req_SI scanning from Prio_q upward with wrap at NUM_REQ-1 -> 0. Otherwise Gnt_SO=0. Gnt_SO is never asserted without the matching Req_SI.
- Operand outputs: muxed from the granted requester. With no grant they are held at requester Prio_q's inputs (don't-care; Stage_en_SO[0] is low).
- Pointer update: on an accepted grant to index g, Prio_q <= (g==NUM_REQ-1) ? 0 : g+1. Otherwise Prio_q holds.
- Advance (~Stall):
  - Valid_q[0] <= issue; Valid_q[k] <= Valid_q[k-1]; Id_q follows Valid_q.
  - Stage_en_SO[0] = issue; Stage_en_SO[k] = Valid_q[k-1].
- Stall: Valid_q, Id_q and Prio_q hold; Stage_en_SO = 0.
- Result: Res_valid_SO = Valid_q[LATENCY-1]; Res_id_DO = Id_q[LATENCY-1]. Once asserted, Res_valid_SO and Res_id_DO stay stable until Res_ready_SI.
- Latency: an operation issued in cycle t presents its result in cycle t+LATENCY when there is no stall. Sustained throughput is 1 op/cycle.
- Flush_SI: next cycle all Valid_q = 0 and no grant in the flush cycle. Prio_q is kept. Flush takes precedence over stall.
- Reset asserted mid-operation: all state cleared asynchronously; in-flight operations are lost.
- Busy_SO = |Valid_q.

Optional Feature:
- FMAC_BUBBLE_COLLAPSE_EN defined:
  - Stall is per stage: stage k holds only if stage k and every stage downstream of it are valid and the output is stalled.
  - Upstream bubbles are squeezed, and issue is allowed while Valid_q[0]=0 even with the output stalled.
  - Stage_en_SO[k] asserts only for stages that move.
- FMAC_BUBBLE_COLLAPSE_EN undefined: global stall exactly as in Behaviour.

Test Plan:
- Reset: Rst_RBI=0 with Req_SI=2'b11 -> Gnt_SO=0, Res_valid_SO=0, Busy_SO=0. After release, first grant goes to requester 0.
- Round-robin: NUM_REQ=2, Req_SI=2'b11 for 4 cycles, Res_ready_SI=1 -> grants 01,10,01,10. Res_id_DO sequence 0,1,0,1 starting at cycle 3 (LATENCY=3).
- Operand routing: requester 1 alone with a=0x3F800000, b=0x40000000, c=0x40400000, RM=3'b001 -> Gnt_SO=2'b10. Operand_*_DO/RM_DO equal requester 1's values; Stage_en_SO[0]=1.
- Back-pressure: pipe full, Res_ready_SI=0 for 5 cycles -> Gnt_SO=0 and Stage_en_SO=0 throughout. Res_valid_SO and Res_id_DO stable. Order is preserved after release.
- Flush: 3 in-flight ops, Flush_SI=1 for 1 cycle -> next cycle Busy_SO=0, no Res_valid_SO. Arbitration resumes from the unchanged Prio_q.
- Bubble collapse (macro defined): issue op, idle 1 cycle, issue op, then hold Res_ready_SI=0 -> the bubble is absorbed and Valid_q becomes 3'b111 with a third issue. Without the macro, Valid_q stays 3'b101 and no issue occurs.
